// File: rtl/end_game_overlay_pipe_if.sv
// Avalon-MM slave bus carrying palette writes into the end-game overlay pipe.
interface end_game_overlay_pipe_if;
    logic        AVL_CS;
    logic        AVL_WRITE;
    logic [6:0]  AVL_ADDR;
    logic [15:0] AVL_WRITEDATA;

    modport master (output AVL_CS, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA);
    modport slave  (input  AVL_CS, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA);
endinterface

// File: rtl/end_game_overlay_pipe.sv
// End-game overlay pixel stage: image ROM addressing, writable palette,
// frame-based fade/blink FSM and a 2-stage alpha blend onto the background.
module end_game_overlay_pipe #(
    parameter int FADE_FRAMES  = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           frame_start,
    input  logic [1:0]                     end_game_on,
    input  logic [14:0]                    img_addr,
    input  logic [3:0]                     bg_red,
    input  logic [3:0]                     bg_green,
    input  logic [3:0]                     bg_blue,
    output logic [15:0]                    rom_addr,
    input  logic [3:0]                     rom_data,
    end_game_overlay_pipe_if.slave         avl,
    output logic [3:0]                     Red,
    output logic [3:0]                     Green,
    output logic [3:0]                     Blue,
    output logic [1:0]                     overlay_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FADE = 2'b01,
        ST_SHOW = 2'b10
    } state_e;

    localparam logic [3:0] FADE_LAST  = 4'(FADE_FRAMES - 1);
    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

    // Per-channel blend with level in eighths; the sum never exceeds 120.
    function automatic logic [3:0] blend(input logic [3:0] ovl,
                                         input logic [3:0] bg,
                                         input logic [3:0] lvl);
        logic [7:0] sum;
        sum = ({4'd0, ovl} * {4'd0, lvl}) + ({4'd0, bg} * (8'd8 - {4'd0, lvl}));
        return 4'(sum >> 3);
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  level_q, level_d;
    logic [3:0]  fade_cnt_q, fade_cnt_d;
    logic [5:0]  blink_cnt_q, blink_cnt_d;
    logic        hidden_q, hidden_d;
    logic [1:0]  seen_q, seen_d;
    logic [1:0]  new_mode;

    logic [1:0]  mode_s1_q;
    logic [11:0] bg_s1_q;
    logic [3:0]  lvl_s1_q;

    logic [11:0] palette_q [16];
    logic        pal_we;
    logic        unused_wdata;

    logic [11:0] ovl;
    logic [3:0]  lvl_eff;
    logic [11:0] rgb_d, rgb_q;

    assign rom_addr = (end_game_on != 2'b00) ? {end_game_on == 2'b10, img_addr} : 16'h0000;

    assign pal_we       = avl.AVL_CS && avl.AVL_WRITE && (avl.AVL_ADDR[6:4] == 3'b101);
    assign unused_wdata = ^avl.AVL_WRITEDATA[15:12];

    // A mode seen on the frame_start cycle itself wins over the remembered one.
    assign new_mode = (end_game_on != 2'b00) ? end_game_on : seen_q;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        seen_d      = seen_q;
        state_d     = state_q;
        level_d     = level_q;
        fade_cnt_d  = fade_cnt_q;
        blink_cnt_d = blink_cnt_q;
        hidden_d    = hidden_q;

        if (frame_start) begin
            seen_d = 2'b00;
        end else if (end_game_on != 2'b00) begin
            seen_d = end_game_on;
        end

        if (frame_start) begin
            if (new_mode == 2'b00) begin
                state_d     = ST_IDLE;
                level_d     = 4'd0;
                fade_cnt_d  = 4'd0;
                blink_cnt_d = 6'd0;
                hidden_d    = 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_d    = ST_FADE;
                        level_d    = 4'd1;
                        fade_cnt_d = 4'd0;
                    end
                    ST_FADE: begin
                        if (fade_cnt_q == FADE_LAST) begin
                            fade_cnt_d = 4'd0;
                            level_d    = level_q + 4'd1;
                            if (level_q == 4'd7) state_d = ST_SHOW;
                        end else begin
                            fade_cnt_d = fade_cnt_q + 4'd1;
                        end
                    end
                    ST_SHOW: begin
                        if (new_mode == 2'b11) begin
                            if (blink_cnt_q == BLINK_LAST) begin
                                blink_cnt_d = 6'd0;
                                hidden_d    = ~hidden_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q + 6'd1;
                            end
                        end else begin
                            blink_cnt_d = 6'd0;
                            hidden_d    = 1'b0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            level_q     <= 4'd0;
            fade_cnt_q  <= 4'd0;
            blink_cnt_q <= 6'd0;
            hidden_q    <= 1'b0;
            seen_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            fade_cnt_q  <= fade_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
            seen_q      <= seen_d;
        end
    end

    // NOTE: the palette is a small register file, so it can and must reset to greyscale.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 16; i++) begin
                palette_q[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (pal_we) begin
            palette_q[avl.AVL_ADDR[3:0]] <= avl.AVL_WRITEDATA[11:0];
        end
    end

    // Stage 1 runs alongside the ROM read; the blink-hidden phase is folded into the level here.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_s1_q <= 2'b00;
            bg_s1_q   <= 12'h000;
            lvl_s1_q  <= 4'd0;
        end else begin
            mode_s1_q <= end_game_on;
            bg_s1_q   <= {bg_red, bg_green, bg_blue};
            lvl_s1_q  <= hidden_q ? 4'd0 : level_q;
        end
    end

    assign ovl     = palette_q[rom_data];
    assign lvl_eff = ((mode_s1_q == 2'b00) || (rom_data == 4'd0)) ? 4'd0 : lvl_s1_q;

    always_comb begin
        rgb_d = {blend(ovl[11:8], bg_s1_q[11:8], lvl_eff),
                 blend(ovl[7:4],  bg_s1_q[7:4],  lvl_eff),
                 blend(ovl[3:0],  bg_s1_q[3:0],  lvl_eff)};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign Red           = rgb_q[11:8];
    assign Green         = rgb_q[7:4];
    assign Blue          = rgb_q[3:0];
    assign overlay_state = state_q;

endmodule

// File: tb/tb_end_game_overlay_pipe.sv
// Directed bench for end_game_overlay_pipe: a synchronous ROM model feeds
// palette indices; each scenario task checks colour and FSM state inline.
module tb_end_game_overlay_pipe;

    logic        CLK;
    logic        RESET_N;
    logic        frame_start;
    logic [1:0]  end_game_on;
    logic [14:0] img_addr;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  Red, Green, Blue;
    logic [1:0]  overlay_state;

    int n_vec;
    int n_err;

    logic [3:0] rom_mem [65536];

    end_game_overlay_pipe_if avl_bus ();

    end_game_overlay_pipe #(
        .FADE_FRAMES  (4),
        .BLINK_FRAMES (16)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .frame_start   (frame_start),
        .end_game_on   (end_game_on),
        .img_addr      (img_addr),
        .bg_red        (bg_red),
        .bg_green      (bg_green),
        .bg_blue       (bg_blue),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .avl           (avl_bus),
        .Red           (Red),
        .Green         (Green),
        .Blue          (Blue),
        .overlay_state (overlay_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous image ROM: data follows the address by one cycle.
    always @(posedge CLK) rom_data <= rom_mem[rom_addr];

    task automatic frame(input logic [1:0] mode, input logic [14:0] addr, input logic [11:0] bg);
        @(negedge CLK);
        frame_start = 1'b1;
        end_game_on = 2'b00;
        @(negedge CLK);
        frame_start = 1'b0;
        end_game_on = mode;
        img_addr    = addr;
        {bg_red, bg_green, bg_blue} = bg;
        repeat (3) @(negedge CLK);
    endtask

    task automatic avl_write(input logic cs, input logic wr, input logic [6:0] addr, input logic [15:0] data);
        @(negedge CLK);
        avl_bus.AVL_CS        = cs;
        avl_bus.AVL_WRITE     = wr;
        avl_bus.AVL_ADDR      = addr;
        avl_bus.AVL_WRITEDATA = data;
        @(negedge CLK);
        avl_bus.AVL_CS    = 1'b0;
        avl_bus.AVL_WRITE = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N     = 1'b0;
        end_game_on = 2'b00;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        {bg_red, bg_green, bg_blue} = 12'h567;
        repeat (2) @(negedge CLK);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_rgb got %h want 000", {Red, Green, Blue});
        end
        n_vec++;
        if (overlay_state !== 2'b00) begin
            n_err++;
            $display("FAIL reset_state got %b want 00", overlay_state);
        end
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h567) begin
            n_err++;
            $display("FAIL idle_bg got %h want 567", {Red, Green, Blue});
        end
        n_vec++;
        if (rom_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL idle_rom_addr got %h want 0000", rom_addr);
        end
        n_vec++;
        if (overlay_state !== 2'b00) begin
            n_err++;
            $display("FAIL idle_state got %b want 00", overlay_state);
        end
        {bg_red, bg_green, bg_blue} = 12'h9AB;
        @(negedge CLK);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h567) begin
            n_err++;
            $display("FAIL latency_1cyc got %h want 567", {Red, Green, Blue});
        end
        {bg_red, bg_green, bg_blue} = 12'h123;
        @(negedge CLK);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h9AB) begin
            n_err++;
            $display("FAIL latency_2cyc got %h want 9ab", {Red, Green, Blue});
        end
        @(negedge CLK);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h123) begin
            n_err++;
            $display("FAIL back_to_back got %h want 123", {Red, Green, Blue});
        end
    endtask

    task automatic test_rom_addr();
        @(negedge CLK);
        end_game_on = 2'b10;
        img_addr    = 15'h1234;
        #1;
        n_vec++;
        if (rom_addr !== 16'h9234) begin
            n_err++;
            $display("FAIL rom_addr_lose got %h want 9234", rom_addr);
        end
        @(negedge CLK);
        end_game_on = 2'b01;
        #1;
        n_vec++;
        if (rom_addr !== 16'h1234) begin
            n_err++;
            $display("FAIL rom_addr_win got %h want 1234", rom_addr);
        end
        @(negedge CLK);
        end_game_on = 2'b11;
        #1;
        n_vec++;
        if (rom_addr !== 16'h1234) begin
            n_err++;
            $display("FAIL rom_addr_blink got %h want 1234", rom_addr);
        end
        @(negedge CLK);
        end_game_on = 2'b00;
        #1;
        n_vec++;
        if (rom_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL rom_addr_none got %h want 0000", rom_addr);
        end
        do_reset();
    endtask

    task automatic test_fade();
        frame(2'b01, 15'h0100, 12'h000);
        n_vec++;
        if (overlay_state !== 2'b00) begin
            n_err++;
            $display("FAIL fade_first_frame_state got %b want 00", overlay_state);
        end
        frame(2'b01, 15'h0100, 12'h000);
        n_vec++;
        if (overlay_state !== 2'b01) begin
            n_err++;
            $display("FAIL fade_enter_state got %b want 01", overlay_state);
        end
        n_vec++;
        if ({Red, Green, Blue} !== 12'h111) begin
            n_err++;
            $display("FAIL fade_level1 got %h want 111", {Red, Green, Blue});
        end
        repeat (3) frame(2'b01, 15'h0100, 12'h000);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h111) begin
            n_err++;
            $display("FAIL fade_level1_hold got %h want 111", {Red, Green, Blue});
        end
        frame(2'b01, 15'h0100, 12'h000);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h333) begin
            n_err++;
            $display("FAIL fade_level2 got %h want 333", {Red, Green, Blue});
        end
        repeat (23) frame(2'b01, 15'h0100, 12'h000);
        n_vec++;
        if ({Red, Green, Blue} !== 12'hDDD) begin
            n_err++;
            $display("FAIL fade_level7 got %h want ddd", {Red, Green, Blue});
        end
        n_vec++;
        if (overlay_state !== 2'b01) begin
            n_err++;
            $display("FAIL fade_before_show got %b want 01", overlay_state);
        end
        frame(2'b01, 15'h0100, 12'h000);
        n_vec++;
        if (overlay_state !== 2'b10) begin
            n_err++;
            $display("FAIL show_state got %b want 10", overlay_state);
        end
        n_vec++;
        if ({Red, Green, Blue} !== 12'hFFF) begin
            n_err++;
            $display("FAIL show_full got %h want fff", {Red, Green, Blue});
        end
        frame(2'b01, 15'h0200, 12'h5A3);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h5A3) begin
            n_err++;
            $display("FAIL transparent_idx0 got %h want 5a3", {Red, Green, Blue});
        end
        frame(2'b10, 15'h0100, 12'h000);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h333) begin
            n_err++;
            $display("FAIL lose_grey_idx3 got %h want 333", {Red, Green, Blue});
        end
    endtask

    task automatic test_palette();
        avl_write(1'b1, 1'b1, 7'h53, 16'h0A50);
        frame(2'b10, 15'h0100, 12'h000);
        n_vec++;
        if ({Red, Green, Blue} !== 12'hA50) begin
            n_err++;
            $display("FAIL palette_write got %h want a50", {Red, Green, Blue});
        end
        avl_write(1'b1, 1'b1, 7'h48, 16'h0FFF);
        avl_write(1'b1, 1'b0, 7'h58, 16'h0FFF);
        avl_write(1'b0, 1'b1, 7'h58, 16'h0FFF);
        frame(2'b10, 15'h0300, 12'h000);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h888) begin
            n_err++;
            $display("FAIL palette_ignored got %h want 888", {Red, Green, Blue});
        end
    endtask

    task automatic test_blink();
        logic [11:0] exp;
        for (int c = 0; c <= 48; c++) begin
            frame(2'b11, 15'h0100, 12'h246);
            exp = ((c >= 16 && c < 32) || c >= 48) ? 12'h246 : 12'hFFF;
            n_vec++;
            if ({Red, Green, Blue} !== exp) begin
                n_err++;
                $display("FAIL blink_frame%0d got %h want %h", c, {Red, Green, Blue}, exp);
            end
        end
        n_vec++;
        if (overlay_state !== 2'b10) begin
            n_err++;
            $display("FAIL blink_state got %b want 10", overlay_state);
        end
        frame(2'b01, 15'h0100, 12'h246);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h246) begin
            n_err++;
            $display("FAIL blink_mode_change_lag got %h want 246", {Red, Green, Blue});
        end
        frame(2'b01, 15'h0100, 12'h246);
        n_vec++;
        if ({Red, Green, Blue} !== 12'hFFF) begin
            n_err++;
            $display("FAIL blink_forced_visible got %h want fff", {Red, Green, Blue});
        end
    endtask

    task automatic test_idle();
        frame(2'b00, 15'h0100, 12'h246);
        n_vec++;
        if (overlay_state !== 2'b10) begin
            n_err++;
            $display("FAIL idle_lag_state got %b want 10", overlay_state);
        end
        frame(2'b00, 15'h0100, 12'h246);
        n_vec++;
        if (overlay_state !== 2'b00) begin
            n_err++;
            $display("FAIL idle_return_state got %b want 00", overlay_state);
        end
        frame(2'b01, 15'h0100, 12'h246);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h246) begin
            n_err++;
            $display("FAIL idle_level0 got %h want 246", {Red, Green, Blue});
        end
    endtask

    task automatic test_reset_mid_fade();
        frame(2'b01, 15'h0100, 12'h246);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h357) begin
            n_err++;
            $display("FAIL blend_level1 got %h want 357", {Red, Green, Blue});
        end
        repeat (4) frame(2'b01, 15'h0100, 12'h246);
        n_vec++;
        if ({Red, Green, Blue} !== 12'h568) begin
            n_err++;
            $display("FAIL blend_level2 got %h want 568", {Red, Green, Blue});
        end
        #2;
        RESET_N = 1'b0;
        #1;
        n_vec++;
        if ({Red, Green, Blue} !== 12'h000) begin
            n_err++;
            $display("FAIL async_reset_rgb got %h want 000", {Red, Green, Blue});
        end
        n_vec++;
        if (overlay_state !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset_state got %b want 00", overlay_state);
        end
        @(negedge CLK);
        end_game_on = 2'b00;
        RESET_N     = 1'b1;
        frame(2'b01, 15'h0100, 12'h246);
        n_vec++;
        if (overlay_state !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_idle got %b want 00", overlay_state);
        end
        frame(2'b01, 15'h0100, 12'h246);
        n_vec++;
        if (overlay_state !== 2'b01) begin
            n_err++;
            $display("FAIL post_reset_fade got %b want 01", overlay_state);
        end
        n_vec++;
        if ({Red, Green, Blue} !== 12'h357) begin
            n_err++;
            $display("FAIL post_reset_level1 got %h want 357", {Red, Green, Blue});
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        RESET_N     = 1'b0;
        frame_start = 1'b0;
        end_game_on = 2'b00;
        img_addr    = 15'h0000;
        {bg_red, bg_green, bg_blue} = 12'h000;
        rom_data    = 4'h0;
        avl_bus.AVL_CS        = 1'b0;
        avl_bus.AVL_WRITE     = 1'b0;
        avl_bus.AVL_ADDR      = 7'h00;
        avl_bus.AVL_WRITEDATA = 16'h0000;
        for (int a = 0; a < 65536; a++) rom_mem[a] = 4'h0;
        rom_mem[16'h0100] = 4'hF;
        rom_mem[16'h0200] = 4'h0;
        rom_mem[16'h8100] = 4'h3;
        rom_mem[16'h8300] = 4'h8;

        test_reset();
        test_rom_addr();
        test_fade();
        test_palette();
        test_blink();
        test_idle();
        test_reset_mid_fade();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
